// File: rtl/ring_decoder_monitor.sv
// rtl/ring_decoder_monitor.sv - one-hot ring code decoder with lock tracking and error counting
module ring_decoder_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           ring_in,
    input  logic                       err_clr,
    output logic [$clog2(WIDTH)-1:0]   idx,
    output logic                       idx_valid,
    output logic                       locked,
    output logic                       seq_err,
    output logic                       onehot_err,
    output logic                       wrap_pulse,
    output logic [ERR_CNT_W-1:0]       err_count
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int GC_W  = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic [GC_W-1:0]      good_cnt_q, good_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 idx_valid_q, idx_valid_d;
    logic                 locked_q, locked_d;
    logic                 seq_err_q, seq_err_d;
    logic                 onehot_err_q, onehot_err_d;
    logic                 wrap_q, wrap_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 oh_ok;
    logic                 in_seq;
    logic                 err_event;
    logic [IDX_W-1:0]     hit_idx;
    logic [WIDTH-1:0]     exp_code;

    // Clearing the lowest set bit leaves zero only for a one-hot code.
    assign oh_ok    = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
    assign exp_code = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    assign in_seq   = (ring_in == exp_code);

    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                hit_idx = i[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_cnt_d   = good_cnt_q;
        idx_d        = idx_q;
        idx_valid_d  = 1'b0;
        locked_d     = locked_q;
        seq_err_d    = 1'b0;
        onehot_err_d = 1'b0;
        wrap_d       = 1'b0;

        if (en) begin
            if (oh_ok) begin
                idx_d       = hit_idx;
                idx_valid_d = 1'b1;
            end else begin
                onehot_err_d = 1'b1;
            end

            case (state_q)
                ST_HUNT: begin
                    if (oh_ok) begin
                        prev_d     = ring_in;
                        good_cnt_d = GC_W'(1);
                        state_d    = ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (in_seq) begin
                        prev_d = ring_in;
                        if (good_cnt_q == GC_W'(LOCK_COUNT - 1)) begin
                            good_cnt_d = GC_W'(LOCK_COUNT);
                            state_d    = ST_LOCKED;
                            locked_d   = 1'b1;
                        end else begin
                            good_cnt_d = good_cnt_q + 1'b1;
                        end
                    end else if (oh_ok) begin
                        prev_d     = ring_in;
                        good_cnt_d = GC_W'(1);
                    end else begin
                        good_cnt_d = '0;
                        state_d    = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (in_seq) begin
                        prev_d = ring_in;
                        wrap_d = prev_q[WIDTH-1] && ring_in[0];
                    end else if (oh_ok) begin
                        seq_err_d  = 1'b1;
                        locked_d   = 1'b0;
                        prev_d     = ring_in;
                        good_cnt_d = GC_W'(1);
                        state_d    = ST_ACQ;
                    end else begin
                        locked_d   = 1'b0;
                        good_cnt_d = '0;
                        state_d    = ST_HUNT;
                    end
                end
                default: begin
                    locked_d   = 1'b0;
                    good_cnt_d = '0;
                    state_d    = ST_HUNT;
                end
            endcase
        end
    end

    // A clear coinciding with an error leaves that error counted.
    assign err_event = seq_err_d | onehot_err_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = err_event ? ERR_CNT_W'(1) : '0;
        end else if (err_event && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            prev_q       <= '0;
            good_cnt_q   <= '0;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            locked_q     <= 1'b0;
            seq_err_q    <= 1'b0;
            onehot_err_q <= 1'b0;
            wrap_q       <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_cnt_q   <= good_cnt_d;
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            locked_q     <= locked_d;
            seq_err_q    <= seq_err_d;
            onehot_err_q <= onehot_err_d;
            wrap_q       <= wrap_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign idx        = idx_q;
    assign idx_valid  = idx_valid_q;
    assign locked     = locked_q;
    assign seq_err    = seq_err_q;
    assign onehot_err = onehot_err_q;
    assign wrap_pulse = wrap_q;
    assign err_count  = err_cnt_q;
endmodule

// File: tb/tb_ring_decoder_monitor.sv
// tb/tb_ring_decoder_monitor.sv - directed bench with run-length reference model
module tb_ring_decoder_monitor;
    localparam int W  = 4;
    localparam int LC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] ring_in;
    logic         err_clr;

    logic [1:0] idx_a, idx_b;
    logic       idx_valid_a, idx_valid_b, locked_a, locked_b;
    logic       seq_err_a, seq_err_b, onehot_err_a, onehot_err_b, wrap_a, wrap_b;
    logic [7:0] err_a;
    logic [1:0] err_b;

    int checks = 0;
    int errors = 0;

    // Reference model: run = consecutive in-sequence valid samples
    int   m_idx, m_prev, m_run;
    logic m_valid, m_locked, m_seq, m_oh, m_wrap;
    int   m_err8, m_err2;
    logic armed = 1'b0;

    always #5 clk = ~clk;

    ring_decoder_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .ring_in(ring_in), .err_clr(err_clr),
        .idx(idx_a), .idx_valid(idx_valid_a), .locked(locked_a), .seq_err(seq_err_a),
        .onehot_err(onehot_err_a), .wrap_pulse(wrap_a), .err_count(err_a)
    );

    ring_decoder_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .ring_in(ring_in), .err_clr(err_clr),
        .idx(idx_b), .idx_valid(idx_valid_b), .locked(locked_b), .seq_err(seq_err_b),
        .onehot_err(onehot_err_b), .wrap_pulse(wrap_b), .err_count(err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [W-1:0] r, input logic c, input logic rs);
        int  k;
        bit  ins, was;
        bit  ev;
        en = e; ring_in = r; err_clr = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            m_idx = 0; m_prev = -1; m_run = 0;
            m_valid = 0; m_locked = 0; m_seq = 0; m_oh = 0; m_wrap = 0;
            m_err8 = 0; m_err2 = 0;
            armed = 1'b1;
        end else begin
            m_valid = 0; m_seq = 0; m_oh = 0; m_wrap = 0;
            if (e) begin
                if ($countones(r) == 1) begin
                    k = 0;
                    for (int i = 0; i < W; i++) if (r[i]) k = i;
                    was = m_locked;
                    ins = (m_prev >= 0) && (k == (m_prev + 1) % W);
                    m_run = ins ? ((m_run < LC) ? m_run + 1 : LC) : 1;
                    m_seq = was && !ins;
                    m_wrap = was && ins && (k == 0);
                    m_prev = k;
                    m_idx = k;
                    m_valid = 1;
                end else begin
                    m_oh = 1;
                    m_run = 0;
                    m_prev = -1;
                end
                m_locked = (m_run >= LC);
            end
            ev = m_seq | m_oh;
            if (c) begin
                m_err8 = ev ? 1 : 0;
                m_err2 = ev ? 1 : 0;
            end else if (ev) begin
                m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
                m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("idx", 32'(idx_a), 32'(m_idx));
            chk("idx_valid", 32'(idx_valid_a), 32'(m_valid));
            chk("locked", 32'(locked_a), 32'(m_locked));
            chk("seq_err", 32'(seq_err_a), 32'(m_seq));
            chk("onehot_err", 32'(onehot_err_a), 32'(m_oh));
            chk("wrap_pulse", 32'(wrap_a), 32'(m_wrap));
            chk("err_count", 32'(err_a), 32'(m_err8));
            chk("err_count_w2", 32'(err_b), 32'(m_err2));
            chk("locked_w2", 32'(locked_b), 32'(m_locked));
            chk("onehot_err_w2", 32'(onehot_err_b), 32'(m_oh));
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; ring_in = '0; err_clr = 1'b0;
        step(0, 4'b0000, 0, 1);
        chk("rst_locked", 32'(locked_a), 0);
        chk("rst_err", 32'(err_a), 0);

        // Acquire lock
        step(1, 4'b0001, 0, 0);
        chk("t1_idx0", 32'(idx_a), 0);
        chk("t1_valid", 32'(idx_valid_a), 1);
        step(1, 4'b0010, 0, 0);
        step(1, 4'b0100, 0, 0);
        chk("t1_prelock", 32'(locked_a), 0);
        step(1, 4'b1000, 0, 0);
        chk("t1_locked", 32'(locked_a), 1);
        chk("t1_idx3", 32'(idx_a), 3);

        // Wrap
        step(1, 4'b0001, 0, 0);
        chk("t2_wrap", 32'(wrap_a), 1);
        step(1, 4'b0010, 0, 0);
        chk("t2_nowrap", 32'(wrap_a), 0);

        // Skip while locked
        step(1, 4'b0100, 0, 0);
        step(1, 4'b1000, 0, 0);
        step(1, 4'b0001, 0, 0);
        step(1, 4'b0100, 0, 0);
        chk("t3_seq_err", 32'(seq_err_a), 1);
        chk("t3_err1", 32'(err_a), 1);
        chk("t3_unlocked", 32'(locked_a), 0);
        step(1, 4'b1000, 0, 0);
        step(1, 4'b0001, 0, 0);
        step(1, 4'b0010, 0, 0);
        chk("t3_relock", 32'(locked_a), 1);

        // Invalid codes
        step(1, 4'b0011, 0, 0);
        chk("t4_oh", 32'(onehot_err_a), 1);
        chk("t4_idx_hold", 32'(idx_a), 1);
        chk("t4_valid0", 32'(idx_valid_a), 0);
        step(1, 4'b0000, 0, 0);
        chk("t4_err3", 32'(err_a), 3);
        step(1, 4'b0001, 0, 0);
        chk("t4_acq", 32'(locked_a), 0);
        step(1, 4'b0010, 0, 0);
        step(1, 4'b0100, 0, 0);
        step(1, 4'b1000, 0, 0);
        chk("t4_relock", 32'(locked_a), 1);

        // Disabled samples are ignored
        for (int i = 0; i < 5; i++) step(0, 4'b1111, 0, 0);
        chk("t5_hold_lock", 32'(locked_a), 1);
        chk("t5_err_hold", 32'(err_a), 3);
        step(1, 4'b0001, 0, 0);
        chk("t5_resume_wrap", 32'(wrap_a), 1);
        chk("t5_no_err", 32'(seq_err_a), 0);

        // Saturation, clear, reset
        for (int i = 0; i < 5; i++) step(1, 4'b0000, 0, 0);
        chk("t6_sat", 32'(err_b), 3);
        chk("t6_err8", 32'(err_a), 8);
        step(1, 4'b0000, 1, 0);
        chk("t6_clr_err", 32'(err_b), 1);
        step(0, 4'b0000, 1, 0);
        chk("t6_clr", 32'(err_a), 0);
        step(1, 4'b0001, 0, 0);
        step(1, 4'b0010, 0, 0);
        step(1, 4'b0100, 0, 0);
        step(1, 4'b1000, 0, 0);
        chk("t6_locked", 32'(locked_a), 1);
        step(1, 4'b0011, 0, 1);
        chk("t6_rst_locked", 32'(locked_a), 0);
        chk("t6_rst_idx", 32'(idx_a), 0);
        chk("t6_rst_valid", 32'(idx_valid_a), 0);
        chk("t6_rst_oh", 32'(onehot_err_a), 0);
        step(1, 4'b0010, 0, 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
